// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// default latencies and the 32x32 arithmetic helpers.
package e_mdu_pkg;

  localparam int MDU_OP_W         = 5;
  localparam int MDU_CNT_W        = 4;
  localparam int DEF_MULT_CYCLES  = 5;
  localparam int DEF_DIV_CYCLES   = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 5'd0,
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MFHI  = 5'd5,
    MDU_MFLO  = 5'd6,
    MDU_MTHI  = 5'd7,
    MDU_MTLO  = 5'd8
  } mdu_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_start_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic mdu_res_t mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    p  = ax * bx;
    return '{hi: p[63:32], lo: p[31:0]};
  endfunction

  function automatic mdu_res_t mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return '{hi: p[63:32], lo: p[31:0]};
  endfunction

  function automatic mdu_res_t div_unsigned(input logic [31:0] a, input logic [31:0] b);
    mdu_res_t r;
    r.lo = (b == 32'd0) ? 32'd0 : a / b;
    r.hi = (b == 32'd0) ? 32'd0 : a % b;
    return r;
  endfunction

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing; remainder takes the sign of the dividend.
  function automatic mdu_res_t div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    mdu_res_t    u;
    mdu_res_t    r;
    ma   = a[31] ? -a : a;
    mb   = b[31] ? -b : b;
    u    = div_unsigned(ma, mb);
    r.lo = (a[31] ^ b[31]) ? -u.lo : u.lo;
    r.hi = a[31] ? -u.hi : u.hi;
    return r;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO register pair, a result computed on the
// start edge and held in tHI/tLO, committed after a fixed busy countdown.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                start,
  output logic                busy,
  output logic [31:0]         MDUOut
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

  logic [31:0]          hi_q,  hi_d;
  logic [31:0]          lo_q,  lo_d;
  logic [31:0]          thi_q, thi_d;
  logic [31:0]          tlo_q, tlo_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

  mdu_res_t res_mult;
  mdu_res_t res_multu;
  mdu_res_t res_div;
  mdu_res_t res_divu;

  // Handshake with the stall unit: start is a pure decode of MDUOp and is
  // accepted only on an edge where busy is low; busy is high from the edge
  // after acceptance until the commit edge. start/mt* seen while busy are dropped.
  assign start = is_start_op(MDUOp);
  assign busy  = (cnt_q != '0);

  assign res_mult  = mul_signed(A, B);
  assign res_multu = mul_unsigned(A, B);
  assign res_div   = div_signed(A, B);
  assign res_divu  = div_unsigned(A, B);

  always_comb begin
    MDUOut = 32'd0;
    case (MDUOp)
      MDU_MFHI: MDUOut = hi_q;
      MDU_MFLO: MDUOut = lo_q;
      default:  MDUOut = 32'd0;
    endcase
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    thi_d = thi_q;
    tlo_d = tlo_q;
    cnt_d = cnt_q;
    if (busy) begin
      if (cnt_q == MDU_CNT_W'(1)) begin
        hi_d  = thi_q;
        lo_d  = tlo_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - MDU_CNT_W'(1);
      end
    end else begin
      case (MDUOp)
        MDU_MULT: begin
          thi_d = res_mult.hi;
          tlo_d = res_mult.lo;
          cnt_d = MULT_CNT;
        end
        MDU_MULTU: begin
          thi_d = res_multu.hi;
          tlo_d = res_multu.lo;
          cnt_d = MULT_CNT;
        end
        // A zero divisor snapshots the current HI/LO so the commit is a no-op;
        // HI/LO cannot change meanwhile because mt* is dropped while busy.
        MDU_DIV: begin
          thi_d = (B == 32'd0) ? hi_q : res_div.hi;
          tlo_d = (B == 32'd0) ? lo_q : res_div.lo;
          cnt_d = DIV_CNT;
        end
        MDU_DIVU: begin
          thi_d = (B == 32'd0) ? hi_q : res_divu.hi;
          tlo_d = (B == 32'd0) ? lo_q : res_divu.lo;
          cnt_d = DIV_CNT;
        end
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      thi_q <= 32'd0;
      tlo_q <= 32'd0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: HI/LO moves, mult/div results and latencies,
// zero divisor, async reset mid-operation and back-to-back starts.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;

  int checks;
  int failures;
  int illegal_cnt;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDUOp  (mdu_op),
    .A      (a),
    .B      (b),
    .start  (start),
    .busy   (busy),
    .MDUOut (mdu_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // start or mt* presented while busy: the stall unit must never let this happen
  always @(posedge clk) begin
    if (!reset && busy && (start || mdu_op == MDU_MTHI || mdu_op == MDU_MTLO))
      illegal_cnt = illegal_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdu_op = op;
    a      = av;
    b      = bv;
    tick();
    mdu_op = MDU_NONE;
  endtask

  task automatic read_reg(input logic [4:0] op, output logic [31:0] v);
    mdu_op = op;
    #1;
    v = mdu_out;
    mdu_op = MDU_NONE;
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] v;
    read_reg(MDU_MFHI, v);
    check({tag, "_hi"}, v, ehi);
    read_reg(MDU_MFLO, v);
    check({tag, "_lo"}, v, elo);
  endtask

  logic [31:0] v;
  int          n;

  initial begin
    checks      = 0;
    failures    = 0;
    illegal_cnt = 0;
    reset       = 1'b1;
    mdu_op      = MDU_NONE;
    a           = 32'd0;
    b           = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check_hilo("rst", 32'd0, 32'd0);
    check("idle_out", mdu_out, 32'd0);

    // mthi / mtlo, then async reset mid-sequence
    issue(MDU_MTHI, 32'h1234_5678, 32'd0);
    read_reg(MDU_MFHI, v);
    check("mthi", v, 32'h1234_5678);
    issue(MDU_MTLO, 32'hAAAA_5555, 32'd0);
    read_reg(MDU_MFLO, v);
    check("mtlo", v, 32'hAAAA_5555);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_hilo("rst_mid", 32'd0, 32'd0);
    reset = 1'b0;
    tick();

    // start decode
    mdu_op = MDU_DIVU;
    #1;
    check("start_divu", {31'd0, start}, 32'd1);
    mdu_op = MDU_MFHI;
    #1;
    check("start_mfhi", {31'd0, start}, 32'd0);
    mdu_op = MDU_NONE;
    #1;

    // mult -2 * 3
    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // div -7 / 2
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu 7 / 2
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_cycles", n, 32'd10);
    check_hilo("divu", 32'd1, 32'd3);

    // div overflow corner
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // divu by zero leaves HI/LO untouched after the full latency
    issue(MDU_MTHI, 32'd5, 32'd0);
    issue(MDU_MTLO, 32'd6, 32'd0);
    issue(MDU_DIVU, 32'd9, 32'd0);
    wait_idle(n);
    check("divz_cycles", n, 32'd10);
    check_hilo("divz", 32'd5, 32'd6);

    // reset two cycles into a mult: no commit afterward
    issue(MDU_MULT, 32'd3, 32'd4);
    tick();
    reset = 1'b1;
    #1;
    check("rst_mult_busy", {31'd0, busy}, 32'd0);
    check_hilo("rst_mult", 32'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check_hilo("post_rst", 32'd0, 32'd0);

    // back-to-back: second mult on the completion edge is dropped
    issue(MDU_MTLO, 32'h0000_0011, 32'd0);
    issue(MDU_MULT, 32'd2, 32'd3);
    read_reg(MDU_MFLO, v);
    check("mflo_busy", v, 32'h0000_0011);
    for (int i = 0; i < 4; i++) tick();
    check("pre_cmp_busy", {31'd0, busy}, 32'd1);
    issue(MDU_MULT, 32'd5, 32'd7);
    check("dropped_busy", {31'd0, busy}, 32'd0);
    check_hilo("b2b_first", 32'd0, 32'd6);
    check("illegal_seen", illegal_cnt, 32'd1);
    issue(MDU_MULT, 32'd5, 32'd7);
    check("accept_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b_cycles", n, 32'd5);
    check_hilo("b2b_second", 32'd0, 32'd35);
    check("illegal_final", illegal_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
